// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU.
// It sequences instruction fetch, decode, execute, memory and writeback, drives the IFU
// PC-update controls and the datapath enable strobes, and traps on illegal encodings or on
// a data-memory handshake that never completes.
module mc_ctrl #(
  parameter int unsigned TIMEOUT = 15,  // max mem_ready wait cycles before trapping (1..255)
  parameter int unsigned CNT_W   = 32   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             npc_sel,
  output logic             jctl,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             ext_op,
  output logic [1:0]       alu_op,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WaitW = 8;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluOr  = 2'd2;
  localparam logic [1:0] AluLui = 2'd3;

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExe    = 4'd3,
    StMemRd  = 4'd4,
    StMemWr  = 4'd5,
    StWb     = 4'd6,
    StBranch = 4'd7,
    StJump   = 4'd8,
    StTrap   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    ClsAddu,
    ClsSubu,
    ClsOri,
    ClsLui,
    ClsLw,
    ClsSw,
    ClsBeq,
    ClsJ,
    ClsIll
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_dec, cls_q, cls_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_mem;
  logic             timeout_hit;
  logic             cnt_inc;

  // Decode the live IR fields into an instruction class
  always_comb begin
    cls_dec = ClsIll;
    unique case (opcode)
      OpRtype: begin
        if (funct == FnAddu) begin
          cls_dec = ClsAddu;
        end else if (funct == FnSubu) begin
          cls_dec = ClsSubu;
        end else begin
          cls_dec = ClsIll;
        end
      end
      OpOri:   cls_dec = ClsOri;
      OpLui:   cls_dec = ClsLui;
      OpLw:    cls_dec = ClsLw;
      OpSw:    cls_dec = ClsSw;
      OpBeq:   cls_dec = ClsBeq;
      OpJ:     cls_dec = ClsJ;
      default: cls_dec = ClsIll;
    endcase
  end

  // The class is captured on the DECODE edge so later states see a stable instruction
  always_comb begin
    cls_d = cls_q;
    if (state_q == StDecode) begin
      cls_d = cls_dec;
    end
  end

  assign in_mem      = (state_q == StMemRd) || (state_q == StMemWr);
  // A ready in the final allowed cycle still completes the access normally
  assign timeout_hit = in_mem && !mem_ready && (wait_q == WaitW'(TIMEOUT - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (cls_dec)
          ClsBeq:  state_d = StBranch;
          ClsJ:    state_d = StJump;
          ClsIll:  state_d = StTrap;
          default: state_d = StExe;
        endcase
      end
      StExe: begin
        if (cls_q == ClsLw) begin
          state_d = StMemRd;
        end else if (cls_q == ClsSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StWb;
        end
      end
      StMemRd: begin
        if (mem_ready) begin
          state_d = StWb;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end
      end
      StWb, StBranch, StJump: state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  // Memory wait counter: counts stalled cycles, clears whenever the memory state is left
  always_comb begin
    wait_d = '0;
    if (in_mem && !mem_ready && !timeout_hit) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  // Retire an instruction on every return to FETCH except the one out of INIT
  assign cnt_inc = (state_d == StFetch) && (state_q != StInit) && (state_q != StFetch);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, latched class, wait counter and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StInit;
      cls_q   <= ClsIll;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from the state and the latched instruction class
  always_comb begin
    pc_wr      = 1'b0;
    npc_sel    = 1'b0;
    jctl       = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = AluAdd;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;

    // ALU controls set up in EXE stay stable through MEM and WB
    if ((state_q == StExe) || in_mem || (state_q == StWb)) begin
      unique case (cls_q)
        ClsAddu: alu_op = AluAdd;
        ClsSubu: alu_op = AluSub;
        ClsOri: begin
          alu_op  = AluOr;
          alu_src = 1'b1;
        end
        ClsLui: begin
          alu_op  = AluLui;
          alu_src = 1'b1;
        end
        ClsLw, ClsSw: begin
          alu_op  = AluAdd;
          alu_src = 1'b1;
          ext_op  = 1'b1;
        end
        default: alu_op = AluAdd;
      endcase
    end

    unique case (state_q)
      StFetch: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
      end
      StMemRd: mem_rd = 1'b1;
      StMemWr: mem_wr = 1'b1;
      StWb: begin
        reg_wr     = 1'b1;
        reg_dst    = (cls_q == ClsAddu) || (cls_q == ClsSubu);
        mem_to_reg = (cls_q == ClsLw);
      end
      StBranch: begin
        alu_op  = AluSub;
        alu_src = 1'b0;
        npc_sel = 1'b1;
        pc_wr   = zero;
      end
      StJump: begin
        pc_wr = 1'b1;
        jctl  = 1'b1;
      end
      StTrap:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

  // Structural invariants of the strobe outputs
  a_wr_excl: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({reg_wr, mem_rd, mem_wr}));
  a_pc_ir: assert property (@(posedge clk) disable iff (!reset)
    (pc_wr && ir_wr) |-> (state_q == StFetch));

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl with a per-instruction expected state-sequence model.
module tb_mc_ctrl;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 5;

  localparam int S_INIT = 0, S_FETCH = 1, S_DECODE = 2, S_EXE = 3, S_MEMRD = 4;
  localparam int S_MEMWR = 5, S_WB = 6, S_BRANCH = 7, S_JUMP = 8, S_TRAP = 9;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
  localparam int C_BEQ = 6, C_J = 7, C_ILL = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_wr, npc_sel, jctl, ir_wr, reg_wr, reg_dst, alu_src, ext_op;
  logic [1:0]       alu_op;
  logic             mem_rd, mem_wr, mem_to_reg, trap;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int cnt_model = 0;

  mc_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_wr      (pc_wr),
    .npc_sel    (npc_sel),
    .jctl       (jctl),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_to_reg (mem_to_reg),
    .trap       (trap),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h21) return C_ADDU;
      if (fn == 6'h23) return C_SUBU;
      return C_ILL;
    end
    case (op)
      6'h0d:   return C_ORI;
      6'h0f:   return C_LUI;
      6'h23:   return C_LW;
      6'h2b:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      default: return C_ILL;
    endcase
  endfunction

  // Packed order: pc_wr npc_sel jctl ir_wr reg_wr reg_dst alu_src ext_op alu_op mem_rd mem_wr
  // mem_to_reg trap
  function automatic logic [13:0] obs_ctrl();
    return {pc_wr, npc_sel, jctl, ir_wr, reg_wr, reg_dst, alu_src, ext_op, alu_op,
            mem_rd, mem_wr, mem_to_reg, trap};
  endfunction

  function automatic logic [13:0] exp_ctrl(input int st, input int c, input logic zv);
    logic pw, ns, jc, iw, rw, rd, as, ex, mr, mw, m2r, tr;
    logic [1:0] ao;
    {pw, ns, jc, iw, rw, rd, as, ex, mr, mw, m2r, tr} = '0;
    ao = 2'd0;
    if (st == S_EXE || st == S_MEMRD || st == S_MEMWR || st == S_WB) begin
      case (c)
        C_SUBU:    ao = 2'd1;
        C_ORI:     begin ao = 2'd2; as = 1'b1; end
        C_LUI:     begin ao = 2'd3; as = 1'b1; end
        C_LW, C_SW: begin ao = 2'd0; as = 1'b1; ex = 1'b1; end
        default:   ao = 2'd0;
      endcase
    end
    case (st)
      S_FETCH:  begin iw = 1'b1; pw = 1'b1; end
      S_MEMRD:  mr = 1'b1;
      S_MEMWR:  mw = 1'b1;
      S_WB:     begin rw = 1'b1; rd = (c == C_ADDU || c == C_SUBU); m2r = (c == C_LW); end
      S_BRANCH: begin ao = 2'd1; ns = 1'b1; pw = zv; end
      S_JUMP:   begin pw = 1'b1; jc = 1'b1; end
      S_TRAP:   tr = 1'b1;
      default:  ;
    endcase
    return {pw, ns, jc, iw, rw, rd, as, ex, ao, mr, mw, m2r, tr};
  endfunction

  task automatic check_cycle(input string tag, input int st, input int c, input logic zv);
    check_eq({tag, " state"}, 32'(state), 32'(st));
    check_eq({tag, " ctrl"}, 32'(obs_ctrl()), 32'(exp_ctrl(st, c, zv)));
    check_eq({tag, " cnt"}, 32'(instr_cnt), 32'(cnt_model));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset from posedge+1, releases it one edge later; leaves the DUT in FETCH
  task automatic reset_dut();
    reset = 1'b0;
    cnt_model = 0;
    mem_ready = 1'b0;
    #1;
    check_cycle("rst asserted", S_INIT, C_ILL, 1'b0);
    step();
    check_cycle("rst held", S_INIT, C_ILL, 1'b0);
    reset = 1'b1;
    check_cycle("rst released", S_INIT, C_ILL, 1'b0);
    step();
  endtask

  // Runs one instruction starting from FETCH; waits = mem_ready low cycles before ready
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int waits, input logic zv, output bit trapped);
    int c;
    int seq[$];
    int k;
    int nmem;
    c = classify(op, fn);
    opcode = op;
    funct = fn;
    zero = zv;
    trapped = 1'b0;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (c)
      C_BEQ: seq.push_back(S_BRANCH);
      C_J:   seq.push_back(S_JUMP);
      C_ILL: begin seq.push_back(S_TRAP); trapped = 1'b1; end
      default: begin
        seq.push_back(S_EXE);
        if (c == C_LW || c == C_SW) begin
          nmem = (waits >= int'(TIMEOUT)) ? int'(TIMEOUT) : waits + 1;
          repeat (nmem) seq.push_back(c == C_LW ? S_MEMRD : S_MEMWR);
          if (waits >= int'(TIMEOUT)) begin
            seq.push_back(S_TRAP);
            trapped = 1'b1;
          end else if (c == C_LW) begin
            seq.push_back(S_WB);
          end
        end else begin
          seq.push_back(S_WB);
        end
      end
    endcase
    k = 0;
    foreach (seq[i]) begin
      check_cycle(tag, seq[i], c, zv);
      if (seq[i] == S_MEMRD || seq[i] == S_MEMWR) begin
        mem_ready = (k == waits);
        k++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    mem_ready = 1'b0;
    if (!trapped) begin
      cnt_model = (cnt_model + 1) % (1 << CNT_W);
    end else begin
      repeat (3) begin
        check_cycle({tag, " trap hold"}, S_TRAP, c, zv);
        mem_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
  endtask

  initial begin
    logic [5:0] lop[8];
    logic [5:0] op, fn;
    bit tr;
    int r, waits;
    lop = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};

    #3;
    reset_dut();

    run_instr("addu", 6'h00, 6'h21, 0, 1'b0, tr);
    run_instr("beq taken", 6'h04, 6'h00, 0, 1'b1, tr);
    run_instr("beq not taken", 6'h04, 6'h00, 0, 1'b0, tr);
    run_instr("lw wait3", 6'h23, 6'h00, 3, 1'b0, tr);
    run_instr("lw wait0", 6'h23, 6'h15, 0, 1'b0, tr);
    run_instr("sw wait0", 6'h2b, 6'h00, 0, 1'b0, tr);
    run_instr("sw wait14", 6'h2b, 6'h00, int'(TIMEOUT) - 1, 1'b0, tr);
    run_instr("subu", 6'h00, 6'h23, 0, 1'b1, tr);
    run_instr("ori", 6'h0d, 6'h3f, 0, 1'b0, tr);
    run_instr("lui", 6'h0f, 6'h00, 0, 1'b0, tr);
    run_instr("j", 6'h02, 6'h00, 0, 1'b0, tr);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16) begin
        r = $urandom_range(0, 7);
        op = lop[r];
        fn = (r == 0) ? 6'h21 : (r == 1) ? 6'h23 : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      waits = ($urandom_range(0, 19) < 2) ? int'(TIMEOUT) - 1 + $urandom_range(0, 2)
                                           : $urandom_range(0, 4);
      run_instr("rand", op, fn, waits, 1'($urandom), tr);
      if (tr) reset_dut();
    end

    // Reset in the middle of an addu writeback
    opcode = 6'h00;
    funct = 6'h21;
    check_cycle("midwb fetch", S_FETCH, C_ADDU, 1'b0);
    step();
    step();
    step();
    check_cycle("midwb wb", S_WB, C_ADDU, 1'b0);
    #2;
    reset = 1'b0;
    cnt_model = 0;
    #1;
    check_cycle("midwb async", S_INIT, C_ADDU, 1'b0);
    step();
    reset_dut();

    run_instr("sw timeout", 6'h2b, 6'h00, int'(TIMEOUT) + 5, 1'b0, tr);
    check_eq("sw timeout trapped", 32'(tr), 32'd1);
    reset_dut();

    run_instr("j2", 6'h02, 6'h00, 0, 1'b0, tr);
    run_instr("illegal 3f", 6'h3f, 6'h00, 0, 1'b0, tr);
    check_cycle("final", S_TRAP, C_ILL, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the instruction-fetch unit and datapath of the MIPS-subset CPU. Each instruction is fetched, then decoded into a per-class state sequence. The FSM drives PC write and next-PC selection (npc_sel/jctl) into the IFU, and enable strobes into the register file, ALU and data memory. Data-memory accesses use a ready handshake with a timeout; illegal encodings trap.

Parameters:
TIMEOUT, 15, max cycles waiting for mem_ready in a memory state before trapping (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU equality flag
mem_ready  in  1  data memory done (read data valid / write accepted)
pc_wr  out  1  PC load enable
npc_sel  out  1  1 = branch target (PC+4+offset)
jctl  out  1  1 = jump target
ir_wr  out  1  IR load enable
reg_wr  out  1  register-file write enable
reg_dst  out  1  1 = rd, 0 = rt
alu_src  out  1  1 = extended immediate
ext_op  out  1  1 = sign extend, 0 = zero extend
alu_op  out  2  0 add, 1 sub, 2 or, 3 lui (imm<<16)
mem_rd  out  1  data memory read request
mem_wr  out  1  data memory write request
mem_to_reg  out  1  writeback source = memory
trap  out  1  sticky illegal-instruction / timeout flag
state  out  4  current state encoding, debug
instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- States: INIT=0, FETCH=1, DECODE=2, EXE=3, MEM_RD=4, MEM_WR=5, WB=6, BRANCH=7, JUMP=8, TRAP=9.
- Reset (reset=0, async): state=INIT; all outputs 0; instr_cnt=0; trap=0; wait counter 0. INIT always goes to FETCH next cycle, so no pc_wr is issued while reset is asserted or in the first cycle after release.
- Outputs are Moore: decoded from state and the opcode/funct latched at the DECODE edge. They are valid for the whole cycle the state is held.
- FETCH: ir_wr=1, pc_wr=1, npc_sel=0, jctl=0 (PC<=PC+4). Next state: DECODE.
- DECODE: latch opcode/funct. Next state by instruction:
  - addu (000000/100001), subu (000000/100011), ori (001101), lui (001111), lw (100011), sw (101011): EXE.
  - beq (000100): BRANCH.
  - j (000010): JUMP.
  - Anything else, including an unknown funct: TRAP.
- EXE: alu_op/alu_src/ext_op per instruction.
  - addu: alu_op=0, alu_src=0. subu: alu_op=1, alu_src=0.
  - ori: alu_op=2, alu_src=1, ext_op=0. lui: alu_op=3, alu_src=1.
  - lw/sw: alu_op=0, alu_src=1, ext_op=1.
  - Next state: lw→MEM_RD, sw→MEM_WR, others→WB.
- MEM_RD/MEM_WR: hold mem_rd/mem_wr=1 plus EXE ALU controls. The wait counter increments each cycle mem_ready=0.
  - mem_ready=1: exit (MEM_RD→WB, MEM_WR→FETCH). Sampled even on the first cycle, giving zero-wait access.
  - Counter reaches TIMEOUT with mem_ready=0: TRAP. mem_ready=1 in that same cycle wins (normal exit).
  - Counter clears on exit.
- WB: reg_wr=1.
  - R-type: reg_dst=1. ori/lui: reg_dst=0. lw: reg_dst=0, mem_to_reg=1.
  - EXE ALU controls are held stable. Next state: FETCH.
- BRANCH: alu_op=1, alu_src=0, npc_sel=1, pc_wr=zero. Next state: FETCH.
- JUMP: pc_wr=1, jctl=1. Next state: FETCH.
- TRAP: trap=1, all enables 0. Stays in TRAP until reset.
- instr_cnt increments by 1 on every transition into FETCH from WB, MEM_WR, BRANCH or JUMP; not from INIT. Wraps at 2^CNT_W−1 → 0.
- Cycle counts, FETCH to next FETCH: R/ori/lui 4; lw 5+waits; sw 4+waits; beq 3; j 3.
- pc_wr and ir_wr are never asserted together except in FETCH. reg_wr, mem_rd and mem_wr are mutually exclusive.

Test Plan:
- Reset low mid-WB of addu → state=0, reg_wr=0, instr_cnt=0 immediately. Release → INIT then FETCH; first pc_wr is 2 cycles after release.
- addu (opcode 0, funct 0x21) → states 1,2,3,6,1. reg_wr=1 and reg_dst=1 in WB; instr_cnt +1.
- beq with zero=1, then beq with zero=0 → states 1,2,7. BRANCH cycle: npc_sel=1, pc_wr=1 for the first, pc_wr=0 for the second.
- lw with mem_ready held low 3 cycles then high → MEM_RD held 4 cycles, then WB with mem_to_reg=1. Total 8 cycles FETCH to FETCH.
- sw with mem_ready never asserted, TIMEOUT=15 → TRAP after 15 MEM_WR cycles. trap=1 and stays 1 across further clocks; instr_cnt unchanged.
- j (0x02) → JUMP with pc_wr=1, jctl=1. Then opcode 0x3F → TRAP from DECODE.
